// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a fixed-latency MMU port through IDLE/ISSUE/WAIT/RESP.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned half/word accesses are rejected instead of aligned down.
module load_store_unit #(
  parameter int READ_LAT = 2
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [6:0]  mmu_address,
  output logic [3:0]  mmu_bytesel,
  output logic [31:0] mmu_wdata,
  output logic        mmu_rw,
  output logic        mmu_retrieve,
  input  logic [31:0] mmu_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;
  logic        we_r;

  logic        f3_ok;
  logic        misalign;
  logic        req_err;
  logic [6:0]  addr_eff;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] lane_data;
  logic [31:0] load_ext;

  // Decode the incoming request: legality, effective address, lane enables and store data.
  always_comb begin
    f3_ok    = 1'b0;
    misalign = 1'b0;
    addr_eff = req_addr[6:0];
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~req_we;
      default:                f3_ok = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_funct3[1:0] == 2'b01) begin
      misalign = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misalign = (req_addr[1:0] != 2'b00);
    end else begin
      misalign = 1'b0;
    end
`else
    if (req_funct3[1:0] == 2'b01) begin
      addr_eff = {req_addr[6:1], 1'b0};
    end else if (req_funct3[1:0] == 2'b10) begin
      addr_eff = {req_addr[6:2], 2'b00};
    end else begin
      addr_eff = req_addr[6:0];
    end
`endif
    req_err = (req_addr[31:7] != 25'd0) || !f3_ok || misalign;
    case (req_funct3[1:0])
      2'b00: begin
        be_next = 4'b0001 << addr_eff[1:0];
        wd_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next = addr_eff[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next = 4'b1111;
        wd_next = req_wdata;
      end
    endcase
    if (!req_we) begin
      wd_next = 32'd0;
    end else begin
      wd_next = wd_next;
    end
  end

  // Align the returned word to the addressed lane and extend per the load width.
  always_comb begin
    lane_data = mmu_rdata >> {lane_r, 3'b000};
    case (f3_r)
      3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_ext = {24'd0, lane_data[7:0]};
      3'b101:  load_ext = {16'd0, lane_data[15:0]};
      default: load_ext = lane_data;
    endcase
    if (we_r) begin
      load_ext = 32'd0;
    end else begin
      load_ext = load_ext;
    end
  end

  // Control FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      f3_r         <= 3'd0;
      lane_r       <= 2'd0;
      we_r         <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
      mmu_address  <= 7'd0;
      mmu_bytesel  <= 4'd0;
      mmu_wdata    <= 32'd0;
      mmu_rw       <= 1'b0;
      mmu_retrieve <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            f3_r      <= req_funct3;
            lane_r    <= addr_eff[1:0];
            we_r      <= req_we;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state        <= ISSUE;
              mmu_retrieve <= 1'b1;
              mmu_address  <= addr_eff;
              mmu_bytesel  <= be_next;
              mmu_wdata    <= wd_next;
              mmu_rw       <= req_we;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          mmu_retrieve <= 1'b0;
          if (READ_LAT == 1) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_rdata  <= load_ext;
            mmu_address <= 7'd0;
            mmu_bytesel <= 4'd0;
            mmu_wdata   <= 32'd0;
            mmu_rw      <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_LAST;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_rdata  <= load_ext;
            mmu_address <= 7'd0;
            mmu_bytesel <= 4'd0;
            mmu_wdata   <= 32'd0;
            mmu_rw      <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          resp_err     <= 1'b0;
          resp_rdata   <= 32'd0;
          mmu_retrieve <= 1'b0;
          mmu_address  <= 7'd0;
          mmu_bytesel  <= 4'd0;
          mmu_wdata    <= 32'd0;
          mmu_rw       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (READ_LAT = 2).
module tb_load_store_unit;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mmu_address;
  logic [3:0]  mmu_bytesel;
  logic [31:0] mmu_wdata;
  logic        mmu_rw;
  logic        mmu_retrieve;
  logic [31:0] mmu_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.READ_LAT(2)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mmu_address(mmu_address), .mmu_bytesel(mmu_bytesel), .mmu_wdata(mmu_wdata),
    .mmu_rw(mmu_rw), .mmu_retrieve(mmu_retrieve), .mmu_rdata(mmu_rdata)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of one transaction, cycle numbers relative to the acceptance edge (cycle 0).
  int          rc, vc, nr;
  logic [3:0]  be1, be2, bev;
  logic [6:0]  a1;
  logic [31:0] w1, rdat;
  logic        rw1, rdy1, err;

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd);
    @(negedge soc_clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; mmu_rdata = rd;
    rc = -1; vc = -1; nr = 0; be1 = 4'd0; be2 = 4'd0; bev = 4'hF; a1 = 7'd0;
    w1 = 32'd0; rw1 = 1'b0; rdy1 = 1'b1; rdat = 32'hX; err = 1'bX;
    for (int c = 1; c <= 10; c++) begin
      @(negedge soc_clk);
      req_valid = 1'b0;
      if (c == 1) rdy1 = req_ready;
      if (c == 2) be2 = mmu_bytesel;
      if (mmu_retrieve) begin
        nr++;
        if (rc < 0) begin
          rc = c; be1 = mmu_bytesel; a1 = mmu_address; w1 = mmu_wdata; rw1 = mmu_rw;
        end
      end
      if (resp_valid && vc < 0) begin
        vc = c; rdat = resp_rdata; err = resp_err; bev = mmu_bytesel;
      end
    end
  endtask

  initial begin
    int nret, nresp, second;
    repeat (2) @(posedge soc_clk);
    @(negedge soc_clk);
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_retrieve", 32'(mmu_retrieve), 32'd0);
    check("rst_bytesel", 32'(mmu_bytesel), 32'd0);

    // SW 0x10
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
    check("sw_retr_cyc", 32'(rc), 32'd1);
    check("sw_rw", 32'(rw1), 32'd1);
    check("sw_be", 32'(be1), 32'hF);
    check("sw_be_wait", 32'(be2), 32'hF);
    check("sw_addr", 32'(a1), 32'h10);
    check("sw_wdata", w1, 32'hDEADBEEF);
    check("sw_resp_cyc", 32'(vc), 32'd3);
    check("sw_err", 32'(err), 32'd0);
    check("sw_rdata", rdat, 32'd0);
    check("sw_busy", 32'(rdy1), 32'd0);
    check("sw_be_resp", 32'(bev), 32'd0);
    check("sw_nretr", 32'(nr), 32'd1);

    // LB / LBU 0x13
    run_req(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FFFFFF);
    check("lb_be", 32'(be1), 32'h8);
    check("lb_rw", 32'(rw1), 32'd0);
    check("lb_rdata", rdat, 32'hFFFFFF80);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FFFFFF);
    check("lbu_rdata", rdat, 32'h00000080);

    // SH / LHU 0x22, LH 0x20
    run_req(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0);
    check("sh_be", 32'(be1), 32'hC);
    check("sh_wdata", w1, 32'hABCDABCD);
    run_req(1'b0, 3'b101, 32'h22, 32'h0, 32'hABCD0000);
    check("lhu_rdata", rdat, 32'h0000ABCD);
    run_req(1'b0, 3'b001, 32'h20, 32'h0, 32'h00008001);
    check("lh_be", 32'(be1), 32'h3);
    check("lh_rdata", rdat, 32'hFFFF8001);

    // SB 0x05
    run_req(1'b1, 3'b000, 32'h05, 32'h000000A5, 32'h0);
    check("sb_be", 32'(be1), 32'h2);
    check("sb_wdata", w1, 32'hA5A5A5A5);
    check("sb_addr", 32'(a1), 32'h05);

    // Errors: out of range, bad load funct3, bad store funct3
    run_req(1'b0, 3'b010, 32'h80, 32'h0, 32'h12345678);
    check("range_resp_cyc", 32'(vc), 32'd1);
    check("range_err", 32'(err), 32'd1);
    check("range_nretr", 32'(nr), 32'd0);
    check("range_rdata", rdat, 32'd0);
    run_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0);
    check("ld_f3_err", 32'(err), 32'd1);
    check("ld_f3_nretr", 32'(nr), 32'd0);
    run_req(1'b1, 3'b100, 32'h0, 32'h0, 32'h0);
    check("st_f3_err", 32'(err), 32'd1);

    // Misaligned LW 0x06
    run_req(1'b0, 3'b010, 32'h06, 32'h0, 32'h11223344);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_err", 32'(err), 32'd1);
    check("mis_nretr", 32'(nr), 32'd0);
`else
    check("mis_addr", 32'(a1), 32'h04);
    check("mis_err", 32'(err), 32'd0);
    check("mis_rdata", rdat, 32'h11223344);
`endif

    // Reset in WAIT abandons the access
    @(negedge soc_clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    @(negedge soc_clk);
    req_valid = 1'b0;
    @(negedge soc_clk);
    reset = 1'b1;
    @(negedge soc_clk);
    reset = 1'b0;
    check("wrst_ready", 32'(req_ready), 32'd1);
    nret = 0; nresp = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) nresp++;
      if (mmu_retrieve) nret++;
      @(negedge soc_clk);
    end
    check("wrst_no_resp", 32'(nresp), 32'd0);
    check("wrst_no_retr", 32'(nret), 32'd0);

    // Held req_valid: accepted only in IDLE, at cycles 0 and 4
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    nret = 0; nresp = 0; second = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge soc_clk);
      if (c == 8) req_valid = 1'b0;
      if (c == 2) check("b2b_busy", 32'(req_ready), 32'd0);
      if (mmu_retrieve) begin
        nret++;
        if (nret == 2) second = c;
      end
      if (resp_valid) nresp++;
    end
    check("b2b_nretr", 32'(nret), 32'd2);
    check("b2b_second", 32'(second), 32'd5);
    check("b2b_nresp", 32'(nresp), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
